// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: clears the datapath, skips the pipeline-fill symbols,
// then accumulates squared slicer error and symbol-error counts per 2^WINDOW_LOG2 window.
module mer_meas_ctrl #(
  parameter int WINDOW_LOG2 = 10,
  parameter int SETTLE_SYMS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_clk_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic signed [17:0]       error,
  input  logic                     sym_error,
  input  logic                     result_ack,
  output logic                     clear_accum,
  output logic                     busy,
  output logic                     result_valid,
  output logic [17+WINDOW_LOG2:0]  err_sq_sum,
  output logic [WINDOW_LOG2:0]     err_count,
  output logic                     overrun
);

  localparam int ACC_W = 18 + WINDOW_LOG2;
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_SYMS);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             settle_cnt_q, settle_cnt_d;
  logic [WINDOW_LOG2-1:0] sym_idx_q, sym_idx_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clear_q, clear_d;
  logic                   valid_q, valid_d;
  logic [ACC_W-1:0]       sum_q, sum_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overrun_q, overrun_d;

  // Square is never negative; bits [34:17] give the 1s17 square rescaled to 18 bits.
  logic signed [35:0] prod;
  logic [17:0]        sq;
  logic               unused_prod_bits;
  assign prod             = error * error;
  assign sq               = prod[34:17];
  assign unused_prod_bits = &{1'b0, prod[35], prod[16:0]};

  logic [8:0] settle_inc;
  logic       last_sym;
  assign settle_inc = {1'b0, settle_cnt_q} + 9'd1;
  assign last_sym   = (sym_idx_q == {WINDOW_LOG2{1'b1}});

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sym_idx_d    = sym_idx_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    clear_d      = 1'b0;
    valid_d      = valid_q;
    sum_d        = sum_q;
    count_d      = count_q;
    overrun_d    = overrun_q;

    if (valid_q && result_ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          clear_d   = 1'b1;
          overrun_d = 1'b0;
          state_d   = (SETTLE_SYMS == 0) ? ST_MEASURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (sym_clk_en) begin
          if (settle_inc == SETTLE_LAST) begin
            state_d      = ST_MEASURE;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_inc[7:0];
          end
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          acc_d     = '0;
          cnt_d     = '0;
          sym_idx_d = '0;
        end else if (sym_clk_en) begin
          if (last_sym) begin
            // Result includes the final symbol; an ack in the same cycle is superseded.
            sum_d     = acc_q + ACC_W'(sq);
            count_d   = cnt_q + CNT_W'(sym_error);
            valid_d   = 1'b1;
            overrun_d = overrun_q | (valid_q & ~result_ack);
            acc_d     = '0;
            cnt_d     = '0;
            sym_idx_d = '0;
            if (continuous) begin
              clear_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            acc_d     = acc_q + ACC_W'(sq);
            cnt_d     = cnt_q + CNT_W'(sym_error);
            sym_idx_d = sym_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      sym_idx_q    <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      clear_q      <= 1'b0;
      valid_q      <= 1'b0;
      sum_q        <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sym_idx_q    <= sym_idx_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      clear_q      <= clear_d;
      valid_q      <= valid_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign clear_accum  = clear_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = valid_q;
  assign err_sq_sum   = sum_q;
  assign err_count    = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Randomized bench for mer_meas_ctrl: window results are predicted from the symbol
// stream with plain arithmetic (sum of (e*e)>>17, count of symbol errors).
module tb_mer_meas_ctrl;

  localparam int W      = 4;
  localparam int SETTLE = 2;
  localparam int N      = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, sym_clk_en, start, abort, continuous, sym_error, result_ack;
  logic signed [17:0] error;
  logic              clear_accum, busy, result_valid, overrun;
  logic [17+W:0]     err_sq_sum;
  logic [W:0]        err_count;

  logic              start0, en0, clr0, busy0, valid0, ovr0;
  logic [17+W:0]     sum0;
  logic [W:0]        cnt0;

  int n_checks = 0;
  int n_pass   = 0;
  int clr_pulses = 0;

  always @(posedge clk) if (clear_accum) clr_pulses++;

  mer_meas_ctrl #(.WINDOW_LOG2(W), .SETTLE_SYMS(SETTLE)) dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start), .abort(abort),
    .continuous(continuous), .error(error), .sym_error(sym_error), .result_ack(result_ack),
    .clear_accum(clear_accum), .busy(busy), .result_valid(result_valid),
    .err_sq_sum(err_sq_sum), .err_count(err_count), .overrun(overrun)
  );

  mer_meas_ctrl #(.WINDOW_LOG2(W), .SETTLE_SYMS(0)) dut0 (
    .clk(clk), .reset(reset), .sym_clk_en(en0), .start(start0), .abort(abort),
    .continuous(continuous), .error(error), .sym_error(sym_error), .result_ack(result_ack),
    .clear_accum(clr0), .busy(busy0), .result_valid(valid0),
    .err_sq_sum(sum0), .err_count(cnt0), .overrun(ovr0)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int gap, input logic signed [17:0] e, input logic se, input logic ab);
    repeat (gap - 1) tick();
    sym_clk_en = 1'b1;
    error      = e;
    sym_error  = se;
    abort      = ab;
    tick();
    sym_clk_en = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic begin_run(input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start accepted: clear_accum=%0b busy=%0b", clear_accum, busy);
    chk("clear_after_start", clear_accum, 1);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < SETTLE; i++) strobe(gap, 18'($urandom), 1'b1, 1'b0);
    chk("busy_after_settle", busy, 1);
  endtask

  // gap 0 = random strobe spacing 1..4 clk; mode picks the error pattern.
  task automatic run_meas(input int gap, input int mode, input bit abort_last,
                          input bit cont, input bit exp_ovr, input bit exp_vb);
    longint exp_sum = 0;
    longint exp_cnt = 0;
    logic signed [17:0] e;
    logic se;
    int g;
    continuous = cont;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       begin e = 18'sd4096;  se = 1'b0; end
        1:       begin e = 18'h20000;  se = ((k % 2) == 0); end
        2:       begin e = 18'h20000;  se = 1'b1; end
        default: begin e = 18'($urandom); se = 1'($urandom); end
      endcase
      g = (gap == 0) ? int'($urandom_range(1, 4)) : gap;
      if (k == N - 1) begin
        start = 1'b0;
        chk("valid_before_final", result_valid, exp_vb);
      end
      strobe(g, e, se, abort_last && (k == N - 1));
      if (!(abort_last && (k == N - 1))) begin
        exp_sum += (longint'(e) * longint'(e)) >>> 17;
        exp_cnt += longint'(se);
      end
    end
    if (abort_last) begin
      $display("abort on final strobe: busy=%0b valid=%0b", busy, result_valid);
      chk("abort_busy", busy, 0);
      chk("abort_valid", result_valid, 0);
    end else begin
      $display("window: sum=%0d (exp %0d) count=%0d (exp %0d) ovr=%0b", err_sq_sum, exp_sum,
               err_count, exp_cnt, overrun);
      chk("win_valid", result_valid, 1);
      chk("win_sum", err_sq_sum, exp_sum);
      chk("win_count", err_count, exp_cnt);
      chk("win_busy", busy, cont);
      chk("win_clear", clear_accum, cont);
      chk("win_overrun", overrun, exp_ovr);
    end
  endtask

  task automatic do_ack;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    $display("ack: valid=%0b", result_valid);
    chk("ack_clears_valid", result_valid, 0);
  endtask

  initial begin
    int c0;
    longint es, ec;
    logic signed [17:0] e;
    logic se;
    reset = 1'b0; sym_clk_en = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    sym_error = 1'b0; result_ack = 1'b0; error = '0; start0 = 1'b0; en0 = 1'b0;
    repeat (3) tick();
    $display("reset: busy=%0b valid=%0b clr=%0b ovr=%0b", busy, result_valid, clear_accum, overrun);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_clear", clear_accum, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sum", err_sq_sum, 0);
    chk("rst_count", err_count, 0);
    reset = 1'b1;
    tick();

    // Single window, then full-scale windows
    c0 = clr_pulses;
    begin_run(4);
    run_meas(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
    chk("single_clear_pulses", clr_pulses - c0, 1);
    begin_run(0);
    run_meas(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();
    begin_run(0);
    run_meas(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack();

    // Continuous, no acks: overrun from window 2
    c0 = clr_pulses;
    begin_run(4);
    run_meas(4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_meas(4, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_meas(4, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("cont_clear_pulses", clr_pulses - c0, 3);
    do_ack();
    chk("overrun_sticky", overrun, 1);

    // Abort beats start in IDLE; abort on the final strobe yields no result
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_vs_start_busy", busy, 0);
    chk("abort_vs_start_clear", clear_accum, 0);
    begin_run(4);
    chk("start_clears_overrun", overrun, 0);
    run_meas(4, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    begin_run(0);
    run_meas(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-window with an unacked result pending
    begin_run(4);
    for (int k = 0; k < 7; k++) strobe(4, 18'($urandom), 1'b1, 1'b0);
    repeat (3) tick();
    sym_clk_en = 1'b1; reset = 1'b0;
    tick();
    sym_clk_en = 1'b0; reset = 1'b1;
    $display("mid-window reset: busy=%0b valid=%0b sum=%0d", busy, result_valid, err_sq_sum);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_sum", err_sq_sum, 0);
    chk("mid_rst_count", err_count, 0);
    chk("mid_rst_overrun", overrun, 0);
    tick();

    // start held high while busy
    c0 = clr_pulses;
    begin_run(0);
    start = 1'b1;
    run_meas(0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_start_clear_pulses", clr_pulses - c0, 1);
    do_ack();

    // SETTLE_SYMS=0 instance with back-to-back strobes
    es = 0; ec = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("s0_clear", clr0, 1);
    for (int k = 0; k < N; k++) begin
      e = 18'($urandom); se = 1'($urandom);
      en0 = 1'b1; error = e; sym_error = se;
      tick();
      es += (longint'(e) * longint'(e)) >>> 17;
      ec += longint'(se);
      if (k == N - 2) chk("s0_valid_early", valid0, 0);
    end
    en0 = 1'b0;
    $display("settle0 window: sum=%0d (exp %0d) count=%0d (exp %0d)", sum0, es, cnt0, ec);
    chk("s0_valid", valid0, 1);
    chk("s0_sum", sum0, es);
    chk("s0_count", cnt0, ec);
    chk("s0_busy", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
